pong_core: RTL

- Parametrised game engine for the Pong design: owns ball position/velocity, wall and paddle collision, scoring, serve timing and win detection for two players.
- Collision is computed geometrically once per video frame from paddle coordinates, not from pixel-scan comparisons.
- Sits between the Player paddle controllers and pixel_gen. New over the previous generation: configurable field/ball/paddle geometry, win score, serve delay, ball speed-up on paddle hits, and pause.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/pong_ball_step.sv | 91 +++++++++
 rtl/pong_core.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong game engine.
// Contents: state encodings, default field/ball/paddle geometry, and the
// signed coordinate type used for position and velocity arithmetic.
package pong_pkg;

  localparam int unsigned POS_W = 12;

  // Signed type wide enough that x+dx and y+dy never wrap.
  typedef logic signed [POS_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int unsigned DEF_H_RES        = 640;
  localparam int unsigned DEF_V_RES        = 480;
  localparam int unsigned DEF_BALL_SIZE    = 8;
  localparam int unsigned DEF_PADDLE_W     = 10;
  localparam int unsigned DEF_PADDLE_H     = 40;
  localparam int unsigned DEF_LEFT_X       = 16;
  localparam int unsigned DEF_RIGHT_X      = 614;
  localparam int unsigned DEF_INIT_SPEED   = 2;
  localparam int unsigned DEF_MAX_SPEED    = 6;
  localparam int unsigned DEF_WIN_SCORE    = 3;
  localparam int unsigned DEF_SCORE_W      = 2;
  localparam int unsigned DEF_SERVE_FRAMES = 60;

endpackage

// File: rtl/pong_ball_step.sv
// One-frame ball step: candidate move, wall reflection, paddle hits.
// Inputs : x, y, dx, dy       current position/velocity
//          paddle1_y/2_y      paddle top edges
// Outputs: x_next..dy_next    position/velocity after this frame
//          hit_left/right     ball struck that paddle this frame
//          miss_left/right    candidate x crossed that outer edge (the core
//                             only scores it when no paddle was hit)
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int unsigned H_RES     = DEF_H_RES,
  parameter int unsigned V_RES     = DEF_V_RES,
  parameter int unsigned BALL_SIZE = DEF_BALL_SIZE,
  parameter int unsigned PADDLE_W  = DEF_PADDLE_W,
  parameter int unsigned PADDLE_H  = DEF_PADDLE_H,
  parameter int unsigned LEFT_X    = DEF_LEFT_X,
  parameter int unsigned RIGHT_X   = DEF_RIGHT_X,
  parameter int unsigned MAX_SPEED = DEF_MAX_SPEED
) (
  input  coord_t     x,
  input  coord_t     y,
  input  coord_t     dx,
  input  coord_t     dy,
  input  logic [8:0] paddle1_y,
  input  logic [8:0] paddle2_y,
  output coord_t     x_next,
  output coord_t     y_next,
  output coord_t     dx_next,
  output coord_t     dy_next,
  output logic       hit_left,
  output logic       hit_right,
  output logic       miss_left,
  output logic       miss_right
);

  localparam coord_t C_ZERO   = '0;
  localparam coord_t C_ONE    = coord_t'(1);
  localparam coord_t C_B      = coord_t'(BALL_SIZE);
  localparam coord_t C_PH     = coord_t'(PADDLE_H);
  localparam coord_t C_MAX    = coord_t'(MAX_SPEED);
  localparam coord_t C_LIM_X  = coord_t'(H_RES - BALL_SIZE);
  localparam coord_t C_LIM_Y  = coord_t'(V_RES - BALL_SIZE);
  localparam coord_t C_LX     = coord_t'(LEFT_X);
  localparam coord_t C_L_EDGE = coord_t'(LEFT_X + PADDLE_W);
  localparam coord_t C_RX     = coord_t'(RIGHT_X);
  localparam coord_t C_R_EDGE = coord_t'(RIGHT_X + PADDLE_W);
  localparam coord_t C_R_STOP = coord_t'(RIGHT_X - BALL_SIZE);

  coord_t nx, ny, adx, ady, spd, p1, p2;

  assign p1 = {3'b000, paddle1_y};
  assign p2 = {3'b000, paddle2_y};

  // Geometry is evaluated on the candidate position, walls before paddles.
  always_comb begin
    nx  = x + dx;
    ny  = y + dy;
    adx = dx[POS_W-1] ? -dx : dx;
    ady = dy[POS_W-1] ? -dy : dy;
    spd = (adx + C_ONE > C_MAX) ? C_MAX : adx + C_ONE;

    y_next  = ny;
    dy_next = dy;
    if (ny <= C_ZERO) begin
      y_next  = C_ZERO;
      dy_next = ady;
    end else if (ny >= C_LIM_Y) begin
      y_next  = C_LIM_Y;
      dy_next = -ady;
    end

    hit_left  = dx[POS_W-1] && (nx <= C_L_EDGE) && (nx + C_B > C_LX) &&
                (ny + C_B > p1) && (ny < p1 + C_PH);
    hit_right = !dx[POS_W-1] && (dx != C_ZERO) && (nx + C_B >= C_RX) &&
                (nx < C_R_EDGE) && (ny + C_B > p2) && (ny < p2 + C_PH);

    x_next  = nx;
    dx_next = dx;
    if (hit_left) begin
      x_next  = C_L_EDGE;
      dx_next = spd;
    end else if (hit_right) begin
      x_next  = C_R_STOP;
      dx_next = -spd;
    end

    miss_left  = (nx <= C_ZERO);
    miss_right = (nx >= C_LIM_X);
  end

endmodule

// File: rtl/pong_core.sv
// Pong game engine: serve timing, ball motion, scoring and win detection.
// Inputs : clk, rst (async active-high), frame_tick, start, pause,
//          paddle1_y / paddle2_y (paddle top edges)
// Outputs: ball_x, ball_y, score1, score2, state, winner, point_pulse
module pong_core
  import pong_pkg::*;
#(
  parameter int unsigned H_RES        = DEF_H_RES,
  parameter int unsigned V_RES        = DEF_V_RES,
  parameter int unsigned BALL_SIZE    = DEF_BALL_SIZE,
  parameter int unsigned PADDLE_W     = DEF_PADDLE_W,
  parameter int unsigned PADDLE_H     = DEF_PADDLE_H,
  parameter int unsigned LEFT_X       = DEF_LEFT_X,
  parameter int unsigned RIGHT_X      = DEF_RIGHT_X,
  parameter int unsigned INIT_SPEED   = DEF_INIT_SPEED,
  parameter int unsigned MAX_SPEED    = DEF_MAX_SPEED,
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned SCORE_W      = DEF_SCORE_W,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic [8:0]         paddle1_y,
  input  logic [8:0]         paddle2_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         state,
  output logic               winner,
  output logic               point_pulse
);

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] S_WIN    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] S_ONE    = SCORE_W'(1);
  localparam coord_t C_CX    = coord_t'((H_RES - BALL_SIZE) / 2);
  localparam coord_t C_CY    = coord_t'((V_RES - BALL_SIZE) / 2);
  localparam coord_t C_INIT  = coord_t'(INIT_SPEED);
  localparam coord_t C_NINIT = -coord_t'(INIT_SPEED);

  state_t           st;
  coord_t           x, y, dx, dy;
  coord_t           x_n, y_n, dx_n, dy_n;
  logic [CNT_W-1:0] cnt;
  logic             serve_left;
  logic             hit_l, hit_r, edge_l, edge_r;
  logic             tick, point_r, point_l;

  assign tick    = frame_tick & ~pause;
  assign point_r = edge_l & ~hit_l & ~hit_r;   // ball left the field on the left
  assign point_l = edge_r & ~hit_l & ~hit_r;   // ball left the field on the right

  pong_ball_step #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL_SIZE),
    .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
    .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X), .MAX_SPEED(MAX_SPEED)
  ) u_step (
    .x(x), .y(y), .dx(dx), .dy(dy),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .x_next(x_n), .y_next(y_n), .dx_next(dx_n), .dy_next(dy_n),
    .hit_left(hit_l), .hit_right(hit_r),
    .miss_left(edge_l), .miss_right(edge_r)
  );

  // Game FSM and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_IDLE;
      x           <= C_CX;
      y           <= C_CY;
      dx          <= C_INIT;
      dy          <= C_INIT;
      cnt         <= '0;
      score1      <= '0;
      score2      <= '0;
      winner      <= 1'b0;
      point_pulse <= 1'b0;
      serve_left  <= 1'b0;
    end else begin
      point_pulse <= 1'b0;
      unique case (st)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score1     <= '0;
            score2     <= '0;
            serve_left <= 1'b0;
            x          <= C_CX;
            y          <= C_CY;
            cnt        <= '0;
            st         <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          // Ball held at centre; velocity aimed at the player who conceded.
          x  <= C_CX;
          y  <= C_CY;
          dx <= serve_left ? C_NINIT : C_INIT;
          dy <= C_INIT;
          if (tick) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              st  <= ST_PLAY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (point_r) begin
              score2      <= (score2 == S_WIN) ? score2 : score2 + S_ONE;
              serve_left  <= 1'b1;
              point_pulse <= 1'b1;
              st          <= ST_POINT;
            end else if (point_l) begin
              score1      <= (score1 == S_WIN) ? score1 : score1 + S_ONE;
              serve_left  <= 1'b0;
              point_pulse <= 1'b1;
              st          <= ST_POINT;
            end else begin
              x  <= x_n;
              y  <= y_n;
              dx <= dx_n;
              dy <= dy_n;
            end
          end
        end
        ST_POINT: begin
          if (score1 == S_WIN || score2 == S_WIN) begin
            winner <= (score2 == S_WIN);
            st     <= ST_OVER;
          end else begin
            x   <= C_CX;
            y   <= C_CY;
            cnt <= '0;
            st  <= ST_SERVE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign ball_x = x[9:0];
  assign ball_y = y[9:0];
  assign state  = st;

endmodule
